mem_access: RTL and testbench

Memory-access pipeline stage downstream of the execute stage. It registers the execute results, runs every load and store over a req/ack data-RAM handshake, aligns and sign- or zero-extends load data by byte lane, and presents registered write-back fields to the WB stage. While a memory access is outstanding it holds the upstream pipeline with a stall.

---
 rtl/mem_access.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_access.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage that sits after EX.
//
// Registers the EX results and runs every load or store over a req/ack
// data-RAM handshake. Load data is aligned by byte lane and then sign- or
// zero-extended. The write-back fields going to WB are registered. While an
// access is outstanding, stall_out holds the upstream pipeline.
//
// Handshake: ram_req is high for every cycle the FSM is in ACCESS. While
// ram_req is high, ram_addr, ram_we, ram_sel and ram_wdata stay stable. The
// access completes on the first rising edge where ram_ack is sampled high with
// ram_req high, and ram_rdata is taken on that same edge. ram_ack is ignored
// while ram_req is low. If no ack arrives within TIMEOUT-1 ACCESS cycles, the
// request is dropped and mem_err pulses for one cycle.
//
// Ports:
//   clk, rst (async, active-low)
//   EX side   : mem_read/write/sign_ext flags, mem_sel_in, mem_write_data_in,
//               result_in (address or ALU value), reg_write_*_in, current_pc_addr_in
//   stall_out : upstream must hold while high (== state is ACCESS)
//   RAM side  : ram_req, ram_we, ram_addr (word aligned), ram_sel, ram_wdata,
//               ram_ack, ram_rdata
//   WB side   : result_out, reg_write_en_out, reg_write_addr_out,
//               current_pc_addr_out
//   mem_err   : one-cycle pulse on access timeout
//   state_dbg : current FSM state (0 = IDLE, 1 = ACCESS)
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_flag_in,
  input  logic        mem_write_flag_in,
  input  logic        mem_sign_ext_flag_in,
  input  logic [3:0]  mem_sel_in,
  input  logic [31:0] mem_write_data_in,
  input  logic [31:0] result_in,
  input  logic        reg_write_en_in,
  input  logic [4:0]  reg_write_addr_in,
  input  logic [31:0] current_pc_addr_in,
  output logic        stall_out,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_wdata,
  input  logic        ram_ack,
  input  logic [31:0] ram_rdata,
  output logic [31:0] result_out,
  output logic        reg_write_en_out,
  output logic [4:0]  reg_write_addr_out,
  output logic [31:0] current_pc_addr_out,
  output logic        mem_err,
  output logic        state_dbg
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  // Abort on the edge where the counter would step to TIMEOUT-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          sign_q, sign_d;
  logic          lrwe_q, lrwe_d;
  logic [4:0]    lrwa_q, lrwa_d;
  logic [31:0]   lpc_q, lpc_d;
  logic [31:0]   result_q, result_d;
  logic          rwe_out_q, rwe_out_d;
  logic [4:0]    rwa_out_q, rwa_out_d;
  logic [31:0]   pc_out_q, pc_out_d;
  logic          err_q, err_d;

  // Lane mask normalisation and store replication for the incoming op.
  logic [3:0]  sel_norm;
  logic [31:0] wdata_rep;
  always_comb begin
    sel_norm  = 4'b1111;
    wdata_rep = mem_write_data_in;
    case (mem_sel_in)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
        sel_norm  = mem_sel_in;
        wdata_rep = {4{mem_write_data_in[7:0]}};
      end
      4'b0011, 4'b1100: begin
        sel_norm  = mem_sel_in;
        wdata_rep = {2{mem_write_data_in[15:0]}};
      end
      default: begin
        sel_norm  = 4'b1111;
        wdata_rep = mem_write_data_in;
      end
    endcase
  end

  // Load alignment. sel_q is already normalised, so there are only seven shapes.
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  always_comb begin
    lane_b   = ram_rdata[7:0];
    lane_h   = ram_rdata[15:0];
    load_val = ram_rdata;
    case (sel_q)
      4'b0001: lane_b = ram_rdata[7:0];
      4'b0010: lane_b = ram_rdata[15:8];
      4'b0100: lane_b = ram_rdata[23:16];
      4'b1000: lane_b = ram_rdata[31:24];
      4'b1100: lane_h = ram_rdata[31:16];
      default: lane_h = ram_rdata[15:0];
    endcase
    case (sel_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000:
        load_val = sign_q ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
      4'b0011, 4'b1100:
        load_val = sign_q ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
      default:
        load_val = ram_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    sign_d    = sign_q;
    lrwe_d    = lrwe_q;
    lrwa_d    = lrwa_q;
    lpc_d     = lpc_q;
    result_d  = result_q;
    rwe_out_d = rwe_out_q;
    rwa_out_d = rwa_out_q;
    pc_out_d  = pc_out_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read_flag_in || mem_write_flag_in) begin
          addr_d    = {result_in[31:2], 2'b00};
          sel_d     = sel_norm;
          wdata_d   = wdata_rep;
          we_d      = mem_write_flag_in;
          sign_d    = mem_sign_ext_flag_in;
          lrwe_d    = reg_write_en_in;
          lrwa_d    = reg_write_addr_in;
          lpc_d     = current_pc_addr_in;
          rwe_out_d = 1'b0;  // bubble into WB while the access runs
          cnt_d     = '0;
          state_d   = ACCESS;
        end else begin
          result_d  = result_in;
          rwe_out_d = reg_write_en_in;
          rwa_out_d = reg_write_addr_in;
          pc_out_d  = current_pc_addr_in;
        end
      end
      ACCESS: begin
        if (ram_ack) begin
          state_d   = IDLE;
          rwa_out_d = lrwa_q;
          pc_out_d  = lpc_q;
          if (we_q) begin
            rwe_out_d = 1'b0;
          end else begin
            rwe_out_d = lrwe_q;
            result_d  = load_val;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          err_d     = 1'b1;
          rwe_out_d = 1'b0;
          result_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      sign_q    <= 1'b0;
      lrwe_q    <= 1'b0;
      lrwa_q    <= '0;
      lpc_q     <= '0;
      result_q  <= '0;
      rwe_out_q <= 1'b0;
      rwa_out_q <= '0;
      pc_out_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      sign_q    <= sign_d;
      lrwe_q    <= lrwe_d;
      lrwa_q    <= lrwa_d;
      lpc_q     <= lpc_d;
      result_q  <= result_d;
      rwe_out_q <= rwe_out_d;
      rwa_out_q <= rwa_out_d;
      pc_out_q  <= pc_out_d;
      err_q     <= err_d;
    end
  end

  // stall_out and ram_req are decoded straight from the state register,
  // so both are registered signals with no extra flop.
  assign stall_out           = (state_q == ACCESS);
  assign ram_req             = (state_q == ACCESS);
  assign ram_we              = we_q;
  assign ram_addr            = addr_q;
  assign ram_sel             = sel_q;
  assign ram_wdata           = wdata_q;
  assign result_out          = result_q;
  assign reg_write_en_out    = rwe_out_q;
  assign reg_write_addr_out  = rwa_out_q;
  assign current_pc_addr_out = pc_out_q;
  assign mem_err             = err_q;
  assign state_dbg           = state_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access, instantiated with TIMEOUT=4.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_flag_in, mem_write_flag_in, mem_sign_ext_flag_in;
  logic [3:0]  mem_sel_in;
  logic [31:0] mem_write_data_in, result_in, current_pc_addr_in;
  logic        reg_write_en_in;
  logic [4:0]  reg_write_addr_in;
  logic        stall_out, ram_req, ram_we, ram_ack, mem_err, state_dbg;
  logic [31:0] ram_addr, ram_wdata, ram_rdata, result_out, current_pc_addr_out;
  logic [3:0]  ram_sel;
  logic        reg_write_en_out;
  logic [4:0]  reg_write_addr_out;

  int tests_run = 0;
  int tests_failed = 0;
  int sc, rc;

  mem_access #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_read_flag_in(mem_read_flag_in), .mem_write_flag_in(mem_write_flag_in),
    .mem_sign_ext_flag_in(mem_sign_ext_flag_in), .mem_sel_in(mem_sel_in),
    .mem_write_data_in(mem_write_data_in), .result_in(result_in),
    .reg_write_en_in(reg_write_en_in), .reg_write_addr_in(reg_write_addr_in),
    .current_pc_addr_in(current_pc_addr_in), .stall_out(stall_out),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .result_out(result_out), .reg_write_en_out(reg_write_en_out),
    .reg_write_addr_out(reg_write_addr_out),
    .current_pc_addr_out(current_pc_addr_out), .mem_err(mem_err),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present one memory op in IDLE, take the accept edge, clear flags
  task automatic accept(input logic rd, input logic wr, input logic sgn,
                        input logic [3:0] sel, input logic [31:0] wd,
                        input logic [31:0] addr, input logic rwe,
                        input logic [4:0] rwa, input logic [31:0] pc);
    mem_read_flag_in     = rd;
    mem_write_flag_in    = wr;
    mem_sign_ext_flag_in = sgn;
    mem_sel_in           = sel;
    mem_write_data_in    = wd;
    result_in            = addr;
    reg_write_en_in      = rwe;
    reg_write_addr_in    = rwa;
    current_pc_addr_in   = pc;
    step();
    mem_read_flag_in  = 1'b0;
    mem_write_flag_in = 1'b0;
    reg_write_en_in   = 1'b0;
  endtask

  // driver: RAM side. Acks in the ACCESS cycle with index ack_delay (0 = first).
  // Returns the number of cycles stall_out and ram_req were seen high (bounded).
  task automatic do_access(input int ack_delay, input logic [31:0] rdata,
                           output int stall_cycles, output int req_cycles);
    stall_cycles = 0;
    req_cycles   = 0;
    while (stall_out === 1'b1 && stall_cycles < 40) begin
      if (ram_req === 1'b1) req_cycles++;
      ram_ack   = (stall_cycles == ack_delay);
      ram_rdata = ram_ack ? rdata : 32'hDEAD_BEEF;
      step();
      stall_cycles++;
    end
    ram_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [141:0] all_out;
    rst = 1'b0;
    mem_read_flag_in = 0; mem_write_flag_in = 0; mem_sign_ext_flag_in = 0;
    mem_sel_in = 0; mem_write_data_in = 0; result_in = 0; reg_write_en_in = 0;
    reg_write_addr_in = 0; current_pc_addr_in = 0; ram_ack = 0; ram_rdata = 0;
    repeat (2) step();
    all_out = {stall_out, ram_req, mem_err, result_out, reg_write_en_out,
               reg_write_addr_out, current_pc_addr_out, ram_we, ram_addr,
               ram_sel, ram_wdata};
    tests_run++;
    if (all_out !== '0) begin
      tests_failed++; $display("FAIL reset_outputs got %h want 0", all_out);
    end
    tests_run++;
    if (state_dbg !== 1'b0) begin
      tests_failed++; $display("FAIL reset_state got %b want 0", state_dbg);
    end
    #2 rst = 1'b1;
    step();
    tests_run++;
    if (stall_out !== 1'b0 || ram_req !== 1'b0) begin
      tests_failed++; $display("FAIL reset_release stall=%b req=%b want 0 0", stall_out, ram_req);
    end
  endtask

  task automatic test_alu();
    result_in = 32'h1234_5678; reg_write_en_in = 1; reg_write_addr_in = 5;
    current_pc_addr_in = 32'h0000_0020;
    step();
    tests_run++;
    if (result_out !== 32'h1234_5678) begin
      tests_failed++; $display("FAIL alu_result got %h want 12345678", result_out);
    end
    tests_run++;
    if ({reg_write_en_out, reg_write_addr_out} !== {1'b1, 5'd5}) begin
      tests_failed++; $display("FAIL alu_wb got en=%b addr=%0d want 1 5", reg_write_en_out, reg_write_addr_out);
    end
    tests_run++;
    if (current_pc_addr_out !== 32'h20 || stall_out !== 1'b0 || ram_req !== 1'b0) begin
      tests_failed++; $display("FAIL alu_ctrl got pc=%h stall=%b req=%b want 20 0 0", current_pc_addr_out, stall_out, ram_req);
    end
  endtask

  task automatic test_signed_byte_load();
    accept(1, 0, 1, 4'b1000, 32'h0, 32'h0000_0103, 1, 5'd7, 32'h40);
    tests_run++;
    if (ram_addr !== 32'h100 || ram_sel !== 4'b1000 || ram_we !== 1'b0) begin
      tests_failed++; $display("FAIL sbyte_req got addr=%h sel=%b we=%b want 100 1000 0", ram_addr, ram_sel, ram_we);
    end
    tests_run++;
    if (reg_write_en_out !== 1'b0) begin
      tests_failed++; $display("FAIL sbyte_bubble got %b want 0", reg_write_en_out);
    end
    do_access(2, 32'h80FF_FF00, sc, rc);
    tests_run++;
    if (sc !== 3 || rc !== 3) begin
      tests_failed++; $display("FAIL sbyte_stall got stall=%0d req=%0d want 3 3", sc, rc);
    end
    tests_run++;
    if (result_out !== 32'hFFFF_FF80) begin
      tests_failed++; $display("FAIL sbyte_result got %h want ffffff80", result_out);
    end
    tests_run++;
    if (reg_write_en_out !== 1'b1 || reg_write_addr_out !== 5'd7 || current_pc_addr_out !== 32'h40) begin
      tests_failed++; $display("FAIL sbyte_wb got en=%b addr=%0d pc=%h want 1 7 40", reg_write_en_out, reg_write_addr_out, current_pc_addr_out);
    end
  endtask

  task automatic test_unsigned_half_load();
    accept(1, 0, 0, 4'b1100, 32'h0, 32'h0000_0206, 1, 5'd8, 32'h44);
    do_access(0, 32'hBEEF_0000, sc, rc);
    // accept edge plus one ACCESS cycle = 2-cycle latency
    tests_run++;
    if (1 + sc !== 2) begin
      tests_failed++; $display("FAIL uhalf_latency got %0d want 2", 1 + sc);
    end
    tests_run++;
    if (result_out !== 32'h0000_BEEF || reg_write_en_out !== 1'b1) begin
      tests_failed++; $display("FAIL uhalf_result got %h en=%b want 0000beef 1", result_out, reg_write_en_out);
    end
  endtask

  task automatic test_store_lanes();
    accept(0, 1, 0, 4'b0010, 32'h0000_00A5, 32'h0000_0301, 1, 5'd4, 32'h48);
    tests_run++;
    if (ram_we !== 1'b1 || ram_wdata !== 32'hA5A5_A5A5 || ram_sel !== 4'b0010 || ram_addr !== 32'h300) begin
      tests_failed++; $display("FAIL bstore_req got we=%b wd=%h sel=%b addr=%h want 1 a5a5a5a5 0010 300", ram_we, ram_wdata, ram_sel, ram_addr);
    end
    do_access(1, 32'h0, sc, rc);
    tests_run++;
    if (sc !== 2 || reg_write_en_out !== 1'b0) begin
      tests_failed++; $display("FAIL bstore_done got cycles=%0d en=%b want 2 0", sc, reg_write_en_out);
    end
    accept(0, 1, 0, 4'b0101, 32'h1122_3344, 32'h0000_0400, 0, 5'd0, 32'h4C);
    tests_run++;
    if (ram_sel !== 4'b1111 || ram_wdata !== 32'h1122_3344) begin
      tests_failed++; $display("FAIL badmask_store got sel=%b wd=%h want 1111 11223344", ram_sel, ram_wdata);
    end
    do_access(0, 32'h0, sc, rc);
    accept(0, 1, 0, 4'b1100, 32'h0000_BEEF, 32'h0000_0502, 0, 5'd0, 32'h50);
    tests_run++;
    if (ram_sel !== 4'b1100 || ram_wdata !== 32'hBEEF_BEEF) begin
      tests_failed++; $display("FAIL hstore got sel=%b wd=%h want 1100 beefbeef", ram_sel, ram_wdata);
    end
    do_access(0, 32'h0, sc, rc);
  endtask

  task automatic test_back_to_back();
    accept(1, 0, 1, 4'b0011, 32'h0, 32'h0000_0010, 1, 5'd10, 32'h60);
    do_access(0, 32'h1234_8765, sc, rc);
    tests_run++;
    if (result_out !== 32'hFFFF_8765 || reg_write_addr_out !== 5'd10) begin
      tests_failed++; $display("FAIL b2b_first got %h addr=%0d want ffff8765 10", result_out, reg_write_addr_out);
    end
    accept(1, 0, 0, 4'b0100, 32'h0, 32'h0000_0022, 1, 5'd11, 32'h64);
    tests_run++;
    if (stall_out !== 1'b1 || ram_addr !== 32'h20) begin
      tests_failed++; $display("FAIL b2b_accept got stall=%b addr=%h want 1 20", stall_out, ram_addr);
    end
    do_access(0, 32'h00C3_0000, sc, rc);
    tests_run++;
    if (result_out !== 32'h0000_00C3 || reg_write_en_out !== 1'b1 || reg_write_addr_out !== 5'd11) begin
      tests_failed++; $display("FAIL b2b_second got %h en=%b addr=%0d want 000000c3 1 11", result_out, reg_write_en_out, reg_write_addr_out);
    end
  endtask

  task automatic test_timeout();
    accept(1, 0, 0, 4'b1111, 32'h0, 32'h0000_0700, 1, 5'd9, 32'h70);
    do_access(99, 32'h0, sc, rc);
    tests_run++;
    if (sc !== 3 || rc !== 3) begin
      tests_failed++; $display("FAIL timeout_cycles got stall=%0d req=%0d want 3 3", sc, rc);
    end
    tests_run++;
    if (mem_err !== 1'b1 || reg_write_en_out !== 1'b0 || result_out !== 32'h0) begin
      tests_failed++; $display("FAIL timeout_err got err=%b en=%b res=%h want 1 0 0", mem_err, reg_write_en_out, result_out);
    end
    result_in = 32'hCAFE_F00D; reg_write_en_in = 1; reg_write_addr_in = 5'd3;
    current_pc_addr_in = 32'h74;
    step();
    reg_write_en_in = 0;
    tests_run++;
    if (mem_err !== 1'b0) begin
      tests_failed++; $display("FAIL timeout_pulse got err=%b want 0", mem_err);
    end
    tests_run++;
    if (result_out !== 32'hCAFE_F00D || reg_write_en_out !== 1'b1 || reg_write_addr_out !== 5'd3) begin
      tests_failed++; $display("FAIL timeout_alu got %h en=%b addr=%0d want cafef00d 1 3", result_out, reg_write_en_out, reg_write_addr_out);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [141:0] all_out;
    accept(0, 1, 0, 4'b1111, 32'h5555_AAAA, 32'h0000_0300, 1, 5'd2, 32'h80);
    result_in = 0; reg_write_addr_in = 0; current_pc_addr_in = 0;
    step();
    tests_run++;
    if (stall_out !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_pre got stall=%b want 1", stall_out);
    end
    #2 rst = 1'b0;
    #1;
    all_out = {stall_out, ram_req, mem_err, result_out, reg_write_en_out,
               reg_write_addr_out, current_pc_addr_out, ram_we, ram_addr,
               ram_sel, ram_wdata};
    tests_run++;
    if (all_out !== '0) begin
      tests_failed++; $display("FAIL rstmid_async got %h want 0", all_out);
    end
    #2 rst = 1'b1;
    step();
    ram_ack = 1'b1; ram_rdata = 32'hFFFF_FFFF;
    step();
    ram_ack = 1'b0;
    tests_run++;
    if (stall_out !== 1'b0 || ram_req !== 1'b0 || state_dbg !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_idle got stall=%b req=%b st=%b want 0 0 0", stall_out, ram_req, state_dbg);
    end
    tests_run++;
    if (result_out !== 32'h0 || reg_write_en_out !== 1'b0 || mem_err !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_lateack got res=%h en=%b err=%b want 0 0 0", result_out, reg_write_en_out, mem_err);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_signed_byte_load();
    test_unsigned_half_load();
    test_store_lanes();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
